// File: rtl/dp_axi_polyvec_loader.sv
// Stream-to-AXI-write converter feeding the triple ping-pong polyvec buffer.
// Walks addr/poly counters over one polyvec, then parks in S_FULL until the controller swaps.
//
// state  | meaning
// S_LOAD | accepting beats, writing poly poly_cnt at address addr_cnt
// S_FULL | polyvec complete, stream stalled until i_swap
module dp_axi_polyvec_loader #(
    parameter int COE_WIDTH      = 39,
    parameter int ADDR_WIDTH     = 9,
    parameter int NUM_POLY       = 3,
    parameter int NUM_BASE_BANK  = 8,
    parameter int WORDS_PER_POLY = 512
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_s_valid,
    output logic                                 o_s_ready,
    input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]   i_s_data,
    input  logic                                 i_s_last,
    input  logic                                 i_swap,
    output logic [NUM_BASE_BANK*NUM_POLY-1:0]    o_axi_we,
    output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0]  o_axi_wraddr,
    output logic [COE_WIDTH*NUM_BASE_BANK-1:0]   o_axi_data,
    output logic                                 o_full,
    output logic                                 o_err,
    output logic [7:0]                           o_vec_cnt
);

    localparam int PW   = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1;
    localparam int WE_W = NUM_BASE_BANK * NUM_POLY;
    localparam int DW   = COE_WIDTH * NUM_BASE_BANK;
    localparam int AW   = ADDR_WIDTH * NUM_BASE_BANK;

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(WORDS_PER_POLY - 1);
    localparam logic [PW-1:0]         POLY_LAST = PW'(NUM_POLY - 1);

    logic [0:0]            state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [PW-1:0]         poly_q,   poly_d;
    logic [WE_W-1:0]       we_q,     we_d;
    logic [AW-1:0]         wraddr_q, wraddr_d;
    logic [DW-1:0]         data_q,   data_d;
    logic                  err_q,    err_d;
    logic [7:0]            vec_q,    vec_d;

    logic accept;
    logic final_beat;

    assign o_s_ready  = ~rst & (state_q == S_LOAD);
    assign accept     = i_s_valid & o_s_ready;
    assign final_beat = (addr_q == ADDR_LAST) && (poly_q == POLY_LAST);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        poly_d   = poly_q;
        we_d     = '0;
        wraddr_d = wraddr_q;
        data_d   = data_q;
        err_d    = err_q;
        vec_d    = vec_q;

        if (accept) begin
            for (int p = 0; p < NUM_POLY; p++) begin
                if (PW'(p) == poly_q) begin
                    we_d[p*NUM_BASE_BANK +: NUM_BASE_BANK] = '1;
                end
            end
            wraddr_d = {NUM_BASE_BANK{addr_q}};
            data_d   = i_s_data;
            // last flag only audited, never used to realign the counters
            if (i_s_last != final_beat) begin
                err_d = 1'b1;
            end
            if (addr_q == ADDR_LAST) begin
                addr_d = '0;
                if (poly_q == POLY_LAST) begin
                    poly_d  = '0;
                    state_d = S_FULL;
                    vec_d   = vec_q + 8'd1;
                end else begin
                    poly_d = poly_q + PW'(1);
                end
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end

        if ((state_q == S_FULL) && i_swap) begin
            state_d = S_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOAD;
            addr_q   <= '0;
            poly_q   <= '0;
            we_q     <= '0;
            wraddr_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            vec_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            poly_q   <= poly_d;
            we_q     <= we_d;
            wraddr_q <= wraddr_d;
            data_q   <= data_d;
            err_q    <= err_d;
            vec_q    <= vec_d;
        end
    end

    assign o_axi_we     = we_q;
    assign o_axi_wraddr = wraddr_q;
    assign o_axi_data   = data_q;
    assign o_full       = (state_q == S_FULL);
    assign o_err        = err_q;
    assign o_vec_cnt    = vec_q;

endmodule

// File: tb/tb_dp_axi_polyvec_loader.sv
// Directed vector table for the polyvec loader: reset, full-rate load, stalls,
// swap handling, framing errors and reset mid-load, plus a throughput sequence.
module tb_dp_axi_polyvec_loader;

    localparam int CW  = 39;
    localparam int AWD = 9;
    localparam int NP  = 3;
    localparam int NB  = 8;
    localparam int WPP = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_s_valid = 1'b0;
    logic                o_s_ready;
    logic [CW*NB-1:0]    i_s_data = '0;
    logic                i_s_last = 1'b0;
    logic                i_swap = 1'b0;
    logic [NB*NP-1:0]    o_axi_we;
    logic [AWD*NB-1:0]   o_axi_wraddr;
    logic [CW*NB-1:0]    o_axi_data;
    logic                o_full;
    logic                o_err;
    logic [7:0]          o_vec_cnt;

    dp_axi_polyvec_loader #(
        .COE_WIDTH(CW), .ADDR_WIDTH(AWD), .NUM_POLY(NP),
        .NUM_BASE_BANK(NB), .WORDS_PER_POLY(WPP)
    ) dut (
        .clk(clk), .rst(rst),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .i_s_data(i_s_data), .i_s_last(i_s_last), .i_swap(i_swap),
        .o_axi_we(o_axi_we), .o_axi_wraddr(o_axi_wraddr), .o_axi_data(o_axi_data),
        .o_full(o_full), .o_err(o_err), .o_vec_cnt(o_vec_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               r, v, l, s;
        int               k;
        bit               erdy;
        logic [NB*NP-1:0] ewe;
        logic [AWD-1:0]   eaddr;
        logic [CW*NB-1:0] edat;
        bit               efull, eerr;
        logic [7:0]       evec;
    } vec_t;

    vec_t             tbl[$];
    logic [AWD-1:0]   cur_addr = '0;
    logic [CW*NB-1:0] cur_dat  = '0;
    int               checks   = 0;
    int               failures = 0;

    function automatic logic [CW*NB-1:0] mkdata(input int k);
        logic [CW*NB-1:0] d;
        for (int b = 0; b < NB; b++) d[b*CW +: CW] = CW'(k * 16 + b + 1);
        return d;
    endfunction

    function automatic logic [AWD*NB-1:0] rep_addr(input logic [AWD-1:0] a);
        logic [AWD*NB-1:0] r;
        for (int b = 0; b < NB; b++) r[b*AWD +: AWD] = a;
        return r;
    endfunction

    // ep = poly written by this cycle's accept, -1 when nothing is written
    task automatic add(input bit r, input bit v, input bit l, input bit s, input int k,
                       input bit erdy, input int ep, input int ea,
                       input bit efull, input bit eerr, input int evec);
        vec_t e;
        logic [NB*NP-1:0] m;
        m = '0;
        if (ep >= 0) begin
            m = 24'h0000FF;
            m = m << (8 * ep);
        end
        if (r) begin
            cur_addr = '0;
            cur_dat  = '0;
        end else if (ep >= 0) begin
            cur_addr = AWD'(ea);
            cur_dat  = mkdata(k);
        end
        e.r = r; e.v = v; e.l = l; e.s = s; e.k = k; e.erdy = erdy;
        e.ewe = m; e.eaddr = cur_addr; e.edat = cur_dat;
        e.efull = efull; e.eerr = eerr; e.evec = 8'(evec);
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input int idx, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        int n;
        int pulses;

        // reset held two cycles
        add(1, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0);
        // full-rate load of vec 1
        for (int k = 0; k < 12; k++)
            add(0, 1, k == 11, 0, k, 1, k / 4, k % 4, k == 11, 0, (k == 11) ? 1 : 0);
        // valid held in S_FULL: nothing accepted
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 20 + i, 0, -1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, -1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, -1, 0, 0, 0, 1);
        // swap during S_LOAD is ignored
        add(0, 0, 0, 1, 0, 1, -1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, -1, 0, 0, 0, 1);
        // vec 2: early last on beat 3, gap after beat 5, swap with final beat ignored
        for (int k = 0; k < 12; k++) begin
            add(0, 1, (k == 3) || (k == 11), k == 11, 100 + k, 1, k / 4, k % 4,
                k == 11, k >= 3, (k == 11) ? 2 : 1);
            if (k == 5)
                for (int g = 0; g < 3; g++) add(0, 0, 0, 0, 90, 1, -1, 0, 0, 1, 1);
        end
        add(0, 1, 0, 0, 130, 0, -1, 0, 1, 1, 2);
        add(0, 1, 0, 0, 131, 0, -1, 0, 1, 1, 2);
        add(0, 0, 0, 1, 0, 0, -1, 0, 0, 1, 2);
        add(0, 0, 0, 0, 0, 1, -1, 0, 0, 1, 2);
        // vec 3: last never asserted, error stays set
        for (int k = 0; k < 12; k++)
            add(0, 1, 0, 0, 200 + k, 1, k / 4, k % 4, k == 11, 1, (k == 11) ? 3 : 2);
        add(0, 0, 0, 1, 0, 0, -1, 0, 0, 1, 3);
        // vec 4 interrupted by reset after 7 beats
        for (int k = 0; k < 7; k++)
            add(0, 1, 0, 0, 300 + k, 1, k / 4, k % 4, 0, 1, 3);
        add(1, 1, 0, 0, 307, 0, -1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 400, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst       = tbl[i].r;
            i_s_valid = tbl[i].v;
            i_s_last  = tbl[i].l;
            i_swap    = tbl[i].s;
            i_s_data  = mkdata(tbl[i].k);
            #1;
            chk("ready", i, 512'(o_s_ready), 512'(tbl[i].erdy));
            @(posedge clk);
            #1;
            chk("we",     i, 512'(o_axi_we),     512'(tbl[i].ewe));
            chk("wraddr", i, 512'(o_axi_wraddr), 512'(rep_addr(tbl[i].eaddr)));
            chk("data",   i, 512'(o_axi_data),   512'(tbl[i].edat));
            chk("full",   i, 512'(o_full),       512'(tbl[i].efull));
            chk("err",    i, 512'(o_err),        512'(tbl[i].eerr));
            chk("vec_cnt", i, 512'(o_vec_cnt),   512'(tbl[i].evec));
        end

        // back-to-back throughput: exactly 12 writes in 12 cycles
        @(negedge clk);
        rst = 1'b1; i_s_valid = 1'b0; i_swap = 1'b0; i_s_last = 1'b0;
        @(negedge clk);
        rst = 1'b0; i_s_valid = 1'b1; i_s_data = mkdata(0);
        n = 0;
        pulses = 0;
        while (!o_full && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (o_axi_we != '0) pulses++;
            i_s_data = mkdata(pulses);
            i_s_last = (pulses == 11);
        end
        i_s_valid = 1'b0;
        chk("tput_full",   0, 512'(o_full),    512'(1));
        chk("tput_cycles", 0, 512'(n),         512'(12));
        chk("tput_writes", 0, 512'(pulses),    512'(12));
        chk("tput_vec",    0, 512'(o_vec_cnt), 512'(1));
        chk("tput_err",    0, 512'(o_err),     512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_axi_polyvec_loader.md
Name: dp_axi_polyvec_loader

Overview:
Upstream feeder for the AXI port of the triple ping-pong polyvec buffer. It accepts a valid/ready coefficient stream, one beat carrying NUM_BASE_BANK coefficients, and converts it into the buffer's AXI write bus: per-bank write enables, replicated bank address and bank data. It sequences address and poly counters across one full polyvec and raises o_full when the polyvec is complete. It then stalls the stream until the controller rotates the buffer with i_swap.

Parameters:
COE_WIDTH, 39, coefficient width in bits
ADDR_WIDTH, 9, bank RAM address width
NUM_POLY, 3, polys per polyvec
NUM_BASE_BANK, 8, banks per poly; coefficients per beat
WORDS_PER_POLY, 512, beats per poly; legal range 1..(1<<ADDR_WIDTH)

Ports:
- Interface rule: one clock; reset is synchronous and active-high.
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_s_valid  in  1  stream beat valid
o_s_ready  out  1  stream ready
i_s_data  in  COE_WIDTH*NUM_BASE_BANK  coefficients; bank b at bits [b*COE_WIDTH +: COE_WIDTH]
i_s_last  in  1  marks the final beat of a polyvec
i_swap  in  1  single-cycle pulse from the controller: buffer rotated, loading may restart
o_axi_we  out  NUM_BASE_BANK*NUM_POLY  write enables; bit p*NUM_BASE_BANK+b targets poly p, bank b
o_axi_wraddr  out  ADDR_WIDTH*NUM_BASE_BANK  per-bank write address
o_axi_data  out  COE_WIDTH*NUM_BASE_BANK  per-bank write data
o_full  out  1  polyvec completely written, waiting for swap
o_err  out  1  sticky framing error
o_vec_cnt  out  8  completed polyvecs, wraps at 255->0

Behaviour:
- States: S_LOAD, S_FULL. Reset enters S_LOAD.
- Reset values:
  - addr_cnt=0, poly_cnt=0.
  - o_axi_we=0, o_axi_wraddr=0, o_axi_data=0.
  - o_full=0, o_err=0, o_vec_cnt=0.
- o_s_ready is combinational:
  - equals 1 in S_LOAD and 0 in S_FULL;
  - equals 0 while rst is high.
- Beat accept: i_s_valid & o_s_ready. Writes are registered, one cycle latency:
  - o_axi_we: all NUM_BASE_BANK bits of poly poly_cnt set, all other bits 0.
  - o_axi_wraddr: {NUM_BASE_BANK{addr_cnt}}, zero-extended from the counter.
  - o_axi_data: i_s_data.
  - o_axi_we returns to 0 on any cycle without an accept.
  - o_axi_wraddr and o_axi_data hold their last value while o_axi_we is 0.
- Counter update on accept:
  - addr_cnt increments.
  - At addr_cnt==WORDS_PER_POLY-1: addr_cnt becomes 0 and poly_cnt increments.
  - At poly_cnt==NUM_POLY-1 together with addr_cnt==WORDS_PER_POLY-1 (final beat):
    - both counters become 0;
    - state goes to S_FULL;
    - o_full goes to 1 in the same cycle as the final write's o_axi_we;
    - o_vec_cnt increments.
- S_FULL:
  - o_full held at 1 and no writes occur.
  - On i_swap: next state S_LOAD, o_full=0, o_s_ready=1 from the following cycle.
- i_swap in S_LOAD is ignored, including in the same cycle as the final beat. The controller only swaps after seeing o_full.
- Framing errors set o_err; it is cleared only by rst:
  - i_s_last=1 on an accepted non-final beat;
  - i_s_last=0 on the accepted final beat.
  - Counting is unaffected by errors; the loader never resynchronises on i_s_last.
- Stalls: with i_s_valid low mid-poly, counters hold and o_axi_we=0. No bubble-dependence: back-to-back beats give one write per cycle.
- Reset mid-load: all state is discarded and the next accepted beat writes poly 0, address 0. Partial polyvec contents in RAM are left as-is.
- Throughput: NUM_POLY*WORDS_PER_POLY cycles per polyvec at full rate.

Test Plan:
- Parameters NUM_POLY=3, NUM_BASE_BANK=8, WORDS_PER_POLY=4, ADDR_WIDTH=9.
- Reset check: hold rst for 2 cycles -> o_s_ready=0 during rst, then 1. o_axi_we=0, o_full=0, o_err=0, o_vec_cnt=0.
- Full-rate load: 12 continuous beats with data=k, last on beat 11.
  - The o_axi_we sequence is 0x0000FF for 4 cycles, 0x00FF00 for 4, then 0xFF0000 for 4.
  - Addresses are 0,1,2,3 repeating.
  - o_full=1 with the 12th write; o_s_ready=0 next; o_vec_cnt=1; o_err=0.
- Stall and backpressure: drop valid for 3 cycles after beat 5, then resume; hold valid in S_FULL.
  - No writes occur during the gaps.
  - Beat 6 writes poly1, addr2.
  - No accept occurs while o_full=1.
- Swap: pulse i_swap 5 cycles after o_full -> o_full=0 and o_s_ready=1 next cycle; the next beat writes we=0x0000FF, addr 0. An i_swap pulse issued during S_LOAD has no effect.
- Framing: i_s_last on beat 3 -> o_err=1 and load completes normally at beat 11. Missing last on the final beat of a second vec -> o_err stays 1.
- Reset mid-load: rst after 7 beats -> the next beat writes we=0x0000FF, addr 0, and o_vec_cnt=0.
